fb_loader: RTL and testbench

Sequential framebuffer writer: accepts a byte stream over a valid/ready handshake and writes it into the 64 K × 8 pixel RAM at consecutive addresses starting at 0. It is the write-side counterpart of the VGA scan-out path, which reads the same RAM sequentially. It sits between the byte source (host link or CPU store path) and the RAM write port (`address`/`data`/`wren`). It reports progress, completion and a running checksum.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_checksum.sv | 41 ++++
 rtl/fb_loader.sv | 139 +++++++++++++
 tb/tb_fb_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions.
// The scan-out reader and the loader both import this package, so the RAM
// geometry and the loader state encoding are defined in one place.
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 16;
  localparam int FB_DATA_WIDTH = 8;
  localparam int FB_PIXELS     = 65536;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } fb_load_state_t;

endpackage

// File: rtl/fb_checksum.sv
// 16-bit running byte-sum accumulator, also used by the readback verifier.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the sum; has priority over add_en
//   add_en     : add add_data to the sum this cycle
//   add_data   : value to add, zero-extended
//   sum        : accumulated sum, mod 2^16
module fb_checksum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_data,
  output logic [15:0]           sum
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + 16'(add_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/fb_loader.sv
// Sequential framebuffer writer. Accepts bytes over a valid/ready handshake
// and writes them to the pixel RAM at consecutive addresses from 0, with a
// one-cycle registered write port.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready depends on state only, never on in_valid;
// in_data is don't-care while in_valid is low.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start               : begin a frame load (sampled only in IDLE)
//   in_valid/in_data    : byte source
//   in_ready            : high in LOAD
//   ram_address/data    : registered RAM write port, valid when ram_wren
//   ram_wren            : write strobe, one cycle per accepted byte
//   busy                : high in LOAD
//   done                : one-cycle pulse in DONE, coincides with last write
//   byte_count          : bytes accepted in current/last load
//   checksum            : sum of accepted bytes mod 2^16
//   dbg_state           : current FSM state
module fb_loader
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = FB_DATA_WIDTH,
  parameter int IMAGE_BYTES = FB_PIXELS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [15:0]           checksum,
  output fb_load_state_t        dbg_state
);

  // Count value held just before the final byte is accepted.
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH+1)'(IMAGE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;

  fb_load_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  logic                  sum_clear;
  logic                  accept;

  assign accept = (state_q == LOAD) && in_valid;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    byte_count_d  = byte_count_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    sum_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          byte_count_d = '0;
          sum_clear    = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          ram_address_d = wr_ptr_q;
          ram_data_d    = in_data;
          ram_wren_d    = 1'b1;
          // Wraps to 0 on a full 2^ADDR_WIDTH frame; LOAD exits on that
          // same accept, so the wrapped pointer is never used.
          wr_ptr_d      = wr_ptr_q + PTR_ONE;
          byte_count_d  = byte_count_q + CNT_ONE;
          if (byte_count_q == LAST_COUNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // start is deliberately not sampled here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      byte_count_q  <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      byte_count_q  <= byte_count_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  fb_checksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (sum_clear),
    .add_en   (accept),
    .add_data (in_data),
    .sum      (checksum)
  );

  assign in_ready    = (state_q == LOAD);
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign byte_count  = byte_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fb_loader.sv
module tb_fb_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_data;
  logic       st [2];
  logic       vl [2];

  logic        rdy  [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        wren [2];
  logic [15:0] ad   [2];
  logic [7:0]  dat  [2];
  logic [16:0] bc   [2];
  logic [15:0] cs   [2];
  logic [1:0]  dbg  [2];

  // Instance 0: small 4-byte frame. Instance 1: full 64 K frame.
  fb_loader #(.IMAGE_BYTES(4)) dut_small (
    .clk(clk), .reset(reset), .start(st[0]), .in_valid(vl[0]), .in_data(in_data),
    .in_ready(rdy[0]), .ram_address(ad[0]), .ram_data(dat[0]), .ram_wren(wren[0]),
    .busy(bsy[0]), .done(dn[0]), .byte_count(bc[0]), .checksum(cs[0]), .dbg_state(dbg[0])
  );

  fb_loader dut_full (
    .clk(clk), .reset(reset), .start(st[1]), .in_valid(vl[1]), .in_data(in_data),
    .in_ready(rdy[1]), .ram_address(ad[1]), .ram_data(dat[1]), .ram_wren(wren[1]),
    .busy(bsy[1]), .done(dn[1]), .byte_count(bc[1]), .checksum(cs[1]), .dbg_state(dbg[1])
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (dut %0d): got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 waiting for start, 1 loading, 2 completion cycle.
  int n_img   [2] = '{4, 65536};
  int m_phase [2];
  int m_count [2];
  int m_sum   [2];
  int m_addr  [2];
  int m_data  [2];
  bit m_wren  [2];
  logic [23:0] exp_q[$];   // expected {address, data} writes of instance 0

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0; m_count[i] = 0; m_sum[i] = 0;
        m_addr[i]  = 0; m_data[i]  = 0; m_wren[i] = 0;
      end else begin
        m_wren[i] = 0;
        case (m_phase[i])
          0: if (st[i]) begin
               m_phase[i] = 1; m_count[i] = 0; m_sum[i] = 0;
             end
          1: if (vl[i]) begin
               // k-th accepted byte goes to address k
               m_wren[i] = 1;
               m_addr[i] = m_count[i] % 65536;
               m_data[i] = int'(in_data);
               if (i == 0) exp_q.push_back({m_addr[0][15:0], in_data});
               m_count[i] = m_count[i] + 1;
               m_sum[i]   = (m_sum[i] + int'(in_data)) % 65536;
               if (m_count[i] == n_img[i]) m_phase[i] = 2;
             end
          default: m_phase[i] = 0;
        endcase
      end
    end
  end

  // ---------------- compare process + observation logs ----------------
  bit          chk_en = 0;
  int          wr_cnt   [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  logic [15:0] last_addr [2];
  logic [15:0] done_addr0;
  logic [15:0] addr_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready",    i, 64'(rdy[i]),  64'(m_phase[i] == 1));
        chk("busy",        i, 64'(bsy[i]),  64'(m_phase[i] == 1));
        chk("done",        i, 64'(dn[i]),   64'(m_phase[i] == 2));
        chk("ram_wren",    i, 64'(wren[i]), 64'(m_wren[i]));
        chk("ram_address", i, 64'(ad[i]),   64'(m_addr[i]));
        chk("ram_data",    i, 64'(dat[i]),  64'(m_data[i]));
        chk("byte_count",  i, 64'(bc[i]),   64'(m_count[i]));
        chk("checksum",    i, 64'(cs[i]),   64'(m_sum[i]));
        if (wren[i]) begin
          wr_cnt[i]++;
          last_addr[i] = ad[i];
          if (i == 0) addr_log.push_back(ad[0]);
        end
        if (dn[i]) done_cnt[i]++;
      end
      if (dn[0] && wren[0]) done_addr0 = ad[0];
      if (wren[0]) begin
        if (exp_q.size() == 0) chk("unexpected write", 0, {40'd0, ad[0], dat[0]}, 64'hFFFF_FFFF);
        else chk("write", 0, {40'd0, ad[0], dat[0]}, 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_q[$];
  logic [6:0] pat_bits = 7'b1011001;   // valid pattern 1,0,0,1,1,0,1 (bit 0 first)

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous valid, 1: fixed gap pattern, 2: random valid
  task automatic run_load(input int i, input int mode, input bit hold_start);
    int k, step, guard;
    bit v;
    st[i] = 1'b1;
    tick();
    if (!hold_start) st[i] = 1'b0;
    k = 0; step = 0; guard = 0;
    while (k < tx_q.size() && guard < 80000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = pat_bits[step % 7];
        default: v = 1'($urandom_range(0, 1));
      endcase
      vl[i]   = v;
      in_data = v ? tx_q[k] : 8'($urandom);
      tick();
      if (v) k++;
      step++; guard++;
    end
    chk("bytes sent before bound", i, 64'(k), 64'(tx_q.size()));
    vl[i] = 1'b0;
    tick();          // completion cycle; a held start is seen here and ignored
    st[i] = 1'b0;
    tick();
  endtask

  task automatic fill_tx(input int n, input bit rnd, input logic [7:0] val);
    tx_q.delete();
    for (int k = 0; k < n; k++) tx_q.push_back(rnd ? 8'($urandom) : val);
  endtask

  // ---------------- main sequence ----------------
  int base, wbase;

  initial begin
    reset = 1'b1; in_data = 8'h00;
    st[0] = 1'b0; st[1] = 1'b0; vl[0] = 1'b0; vl[1] = 1'b0;
    done_addr0 = 16'hDEAD;
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    chk("reset byte_count", 0, 64'(bc[0]), 64'd0);
    chk("reset checksum",   0, 64'(cs[0]), 64'd0);
    chk("reset in_ready",   1, 64'(rdy[1]), 64'd0);
    chk("reset state",      0, 64'(dbg[0]), 64'd0);
    tick();

    // Back-to-back 4-byte frame.
    tx_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    base = addr_log.size(); wbase = wr_cnt[0];
    run_load(0, 0, 1'b0);
    chk("A writes", 0, 64'(wr_cnt[0] - wbase), 64'd4);
    for (int k = 0; k < 4; k++) chk("A address order", 0, 64'(addr_log[base + k]), 64'(k));
    chk("A byte_count", 0, 64'(bc[0]), 64'd4);
    chk("A checksum",   0, 64'(cs[0]), 64'h00A0);
    chk("A model sum",  0, 64'(m_sum[0]), 64'h00A0);
    chk("A done with addr 3", 0, 64'(done_addr0), 64'd3);
    chk("A done pulses", 0, 64'(done_cnt[0]), 64'd1);

    // Same bytes with gaps in in_valid.
    base = addr_log.size(); wbase = wr_cnt[0];
    run_load(0, 1, 1'b0);
    chk("B writes", 0, 64'(wr_cnt[0] - wbase), 64'd4);
    for (int k = 0; k < 4; k++) chk("B address order", 0, 64'(addr_log[base + k]), 64'(k));
    chk("B checksum", 0, 64'(cs[0]), 64'h00A0);

    // in_valid while idle: nothing written.
    wbase = wr_cnt[0];
    vl[0] = 1'b1; in_data = 8'h5A;
    repeat (3) tick();
    vl[0] = 1'b0;
    chk("idle valid writes", 0, 64'(wr_cnt[0] - wbase), 64'd0);

    // start held through LOAD and the completion cycle: no restart.
    fill_tx(4, 1'b1, 8'h00);
    base = addr_log.size();
    run_load(0, 0, 1'b1);
    chk("C state idle", 0, 64'(dbg[0]), 64'd0);
    chk("C byte_count", 0, 64'(bc[0]), 64'd4);
    chk("C first addr", 0, 64'(addr_log[base]), 64'd0);

    // Reset after 2 of 4 bytes, then a fresh load.
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    vl[0] = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    vl[0] = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("D wren after reset", 0, 64'(wren[0]), 64'd0);
    chk("D count after reset", 0, 64'(bc[0]), 64'd0);
    tick();
    fill_tx(4, 1'b1, 8'h00);
    base = addr_log.size();
    run_load(0, 2, 1'b0);
    chk("D restart addr", 0, 64'(addr_log[base]), 64'd0);

    // Several random frames with random gaps.
    for (int f = 0; f < 6; f++) begin
      fill_tx(4, 1'b1, 8'h00);
      run_load(0, 2, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Full 64 K frame of 0xFF.
    fill_tx(65536, 1'b0, 8'hFF);
    run_load(1, 0, 1'b0);
    chk("F writes",     1, 64'(wr_cnt[1]), 64'd65536);
    chk("F last addr",  1, 64'(last_addr[1]), 64'hFFFF);
    chk("F byte_count", 1, 64'(bc[1]), 64'd65536);
    chk("F checksum",   1, 64'(cs[1]), 64'h0000);
    chk("F done pulses", 1, 64'(done_cnt[1]), 64'd1);

    chk("pending writes", 0, 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
